// File: rtl/mc_control.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback.
// Latency: 3 (beq/j), 4 (R-type/addi/sw), 5 (lw) cycles with memory always ready.
// Backpressure: FETCH, MEMRD and MEMWR hold their request until mem_ready=1.
module mc_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [2:0]       alu_op,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_source,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP
  } state_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state;
  logic [2:0] exec_op;
  logic       funct_ok;

  // The branch decision is made in the datapath (pc_write_cond & zero), so the
  // flag is not needed by the sequencer itself.
  logic unused_zero;
  assign unused_zero = zero;

  // R-type funct decode; unsupported funct falls back to ADD and is flagged.
  always_comb begin
    exec_op  = ALU_ADD;
    funct_ok = 1'b1;
    case (funct)
      6'b100000: exec_op = ALU_ADD;
      6'b100010: exec_op = ALU_SUB;
      6'b100100: exec_op = ALU_AND;
      6'b100101: exec_op = ALU_OR;
      6'b101010: exec_op = ALU_SLT;
      default:   funct_ok = 1'b0;
    endcase
  end

  // State sequencing, registered illegal pulse and retired-instruction count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      illegal <= 1'b0;
      case (state)
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_EXEC;
            OP_ADDI:      state <= S_ADDIEX;
            OP_BEQ:       state <= S_BRANCH;
            OP_J:         state <= S_JUMP;
            default: begin
              state   <= S_FETCH;
              illegal <= 1'b1;
            end
          endcase
        end
        S_MEMADR: state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWR: begin
          if (mem_ready) begin
            state   <= S_FETCH;
            retired <= retired + CNT_ONE;
          end
        end
        S_EXEC: begin
          if (funct_ok) begin
            state <= S_ALUWB;
          end else begin
            state   <= S_FETCH;
            illegal <= 1'b1;
          end
        end
        S_ADDIEX: state <= S_ADDIWB;
        S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
          state   <= S_FETCH;
          retired <= retired + CNT_ONE;
        end
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Moore output decode from the state register; EXEC alu_op and FETCH
  // ir/pc strobes additionally look at funct and mem_ready.
  always_comb begin
    alu_op        = 3'b000;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    pc_source     = 2'd0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        alu_op    = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        alu_op    = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = exec_op;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'd2;
      end
      default: ;
    endcase
  end

endmodule
